// File: rtl/bayer_row_buf.sv
// -----------------------------------------------------------------------------
// bayer_row_buf
//   Row buffer in front of the Bayer interpolation core. It takes the pixel
//   stream coming out of the pixel input FIFO, rebuilds line boundaries from a
//   programmed line width, and writes each line into one of three rotating row
//   memories. For every accepted pixel it emits a vertically aligned 3-pixel
//   column (rows y-2, y-1, y) together with its x/y coordinates. The output
//   latency is fixed at 2 sclk cycles.
//
// Optional feature (compile-time macro BAYER_PHASE_EN):
//   adds input bayer_start[1:0], sampled at frame start, and output
//   out_phase[1:0] = {row[0]^bs[1], col[0]^bs[0]}, aligned with out_valid.
//
// Ports
//   sclk            in   system clock
//   rst_n           in   asynchronous active-low reset
//   line_width      in   active pixels per line, sampled at frame start
//                        (0 or > LINE_MAX clamps to LINE_MAX)
//   in_frame_valid  in   frame envelope
//   in_pixel_valid  in   pixel strobe (one pixel per cycle)
//   in_pixel_data   in   pixel value
//   out_frame_valid out  in_frame_valid delayed by 2 cycles
//   out_valid       out  column valid (rows 2 and above only)
//   out_top         out  pixel at (col, row-2)
//   out_mid         out  pixel at (col, row-1)
//   out_bot         out  pixel at (col, row)
//   out_col         out  column of the output column
//   out_row         out  row of out_bot
//   out_eol         out  last column of a line
//   err_short_line  out  1-cycle pulse when a frame ends mid-line
//   bayer_start     in   (BAYER_PHASE_EN only) CFA phase at (0,0)
//   out_phase       out  (BAYER_PHASE_EN only) CFA phase of the output column
// -----------------------------------------------------------------------------
module bayer_row_buf #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 11,
  parameter int ROW_W  = 12
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic [ADDR_W:0]   line_width,
  input  logic              in_frame_valid,
  input  logic              in_pixel_valid,
  input  logic [DATA_W-1:0] in_pixel_data,
`ifdef BAYER_PHASE_EN
  input  logic [1:0]        bayer_start,
  output logic [1:0]        out_phase,
`endif
  output logic              out_frame_valid,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_top,
  output logic [DATA_W-1:0] out_mid,
  output logic [DATA_W-1:0] out_bot,
  output logic [ADDR_W-1:0] out_col,
  output logic [ROW_W-1:0]  out_row,
  output logic              out_eol,
  output logic              err_short_line
);

  localparam int               LINE_MAX   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]  LINE_MAX_W = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ROW_W-1:0] ROW_SAT    = '1;

  // ---------------------------------------------------------------------------
  // Frame tracking and write-side state
  // ---------------------------------------------------------------------------
  logic              fv_q;
  logic              active_reg, active_next;
  logic [ADDR_W-1:0] col_reg, col_next;
  logic [ROW_W-1:0]  row_reg, row_next;
  logic [1:0]        wsel_reg, wsel_next;
  logic [ADDR_W:0]   width_reg, width_next;

  logic              rise, fall, accept, last_col;
  logic [ADDR_W:0]   width_clamped;
  logic [ADDR_W:0]   cur_width;
  logic [ADDR_W-1:0] cur_col;
  logic [ROW_W-1:0]  cur_row;
  logic [1:0]        cur_wsel;

  assign rise = in_frame_valid & ~fv_q;
  assign fall = ~in_frame_valid & fv_q;

  // fv_q resets high so that a frame already in progress when reset releases
  // is not mistaken for a new frame; the active flag keeps its pixels dropped
  // until a genuine low-to-high transition is seen.
  assign accept = in_pixel_valid & in_frame_valid & (active_reg | rise);

  assign width_clamped = ((line_width == '0) || (line_width > LINE_MAX_W)) ?
                         LINE_MAX_W : line_width;

  // In the rise cycle the restarted coordinates and the new width apply to a
  // pixel arriving in that same cycle.
  assign cur_width = rise ? width_clamped : width_reg;
  assign cur_col   = rise ? '0 : col_reg;
  assign cur_row   = rise ? '0 : row_reg;
  assign cur_wsel  = rise ? 2'd0 : wsel_reg;

  assign last_col  = ({1'b0, cur_col} == (cur_width - {{ADDR_W{1'b0}}, 1'b1}));

  always_comb begin
    col_next    = cur_col;
    row_next    = cur_row;
    wsel_next   = cur_wsel;
    width_next  = cur_width;
    active_next = active_reg;
    if (rise) begin
      active_next = 1'b1;
    end else if (fall) begin
      active_next = 1'b0;
    end
    if (accept) begin
      if (last_col) begin
        col_next  = '0;
        row_next  = (cur_row == ROW_SAT) ? cur_row : cur_row + ROW_W'(1);
        wsel_next = (cur_wsel == 2'd2) ? 2'd0 : cur_wsel + 2'd1;
      end else begin
        col_next  = cur_col + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      fv_q       <= 1'b1;
      active_reg <= 1'b0;
      col_reg    <= '0;
      row_reg    <= '0;
      wsel_reg   <= 2'd0;
      width_reg  <= LINE_MAX_W;
    end else begin
      fv_q       <= in_frame_valid;
      active_reg <= active_next;
      col_reg    <= col_next;
      row_reg    <= row_next;
      wsel_reg   <= wsel_next;
      width_reg  <= width_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Row memories: one write port and one registered read port each. The
  // memory being written is never the one whose read data is used, so the
  // read-first behaviour on that memory is irrelevant.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] rd_q [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_row_mem
    logic [DATA_W-1:0] mem [LINE_MAX];
    logic [DATA_W-1:0] rd_data;

    always_ff @(posedge sclk) begin
      if (accept) begin
        if (cur_wsel == 2'(gi)) begin
          mem[cur_col] <= in_pixel_data;
        end
        rd_data <= mem[cur_col];
      end
    end

    assign rd_q[gi] = rd_data;
  end

  // ---------------------------------------------------------------------------
  // Stage 1: coordinates and incoming pixel travel alongside the RAM read
  // ---------------------------------------------------------------------------
  logic              fv_d1;
  logic              s1_valid;
  logic              s1_eol;
  logic [1:0]        s1_wsel;
  logic [DATA_W-1:0] s1_bot;
  logic [ADDR_W-1:0] s1_col;
  logic [ROW_W-1:0]  s1_row;
`ifdef BAYER_PHASE_EN
  logic [1:0]        bs_reg;
  logic [1:0]        cur_bs;
  logic [1:0]        s1_phase;

  assign cur_bs = rise ? bayer_start : bs_reg;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      bs_reg    <= 2'd0;
      s1_phase  <= 2'd0;
      out_phase <= 2'd0;
    end else begin
      bs_reg    <= cur_bs;
      s1_phase  <= {cur_row[0] ^ cur_bs[1], cur_col[0] ^ cur_bs[0]};
      out_phase <= s1_phase;
    end
  end
`endif

  // Rotate the read data so top always holds row-2 and mid holds row-1:
  // with write select W, row-2 lives in (W+1)%3 and row-1 in (W+2)%3.
  logic [DATA_W-1:0] top_data, mid_data;

  always_comb begin
    top_data = rd_q[1];
    mid_data = rd_q[2];
    case (s1_wsel)
      2'd1: begin
        top_data = rd_q[2];
        mid_data = rd_q[0];
      end
      2'd2: begin
        top_data = rd_q[0];
        mid_data = rd_q[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      fv_d1           <= 1'b0;
      s1_valid        <= 1'b0;
      s1_eol          <= 1'b0;
      s1_wsel         <= 2'd0;
      s1_bot          <= '0;
      s1_col          <= '0;
      s1_row          <= '0;
      out_frame_valid <= 1'b0;
      out_valid       <= 1'b0;
      out_top         <= '0;
      out_mid         <= '0;
      out_bot         <= '0;
      out_col         <= '0;
      out_row         <= '0;
      out_eol         <= 1'b0;
      err_short_line  <= 1'b0;
    end else begin
      fv_d1           <= in_frame_valid;
      s1_valid        <= accept;
      s1_eol          <= accept & last_col;
      s1_wsel         <= cur_wsel;
      s1_bot          <= in_pixel_data;
      s1_col          <= cur_col;
      s1_row          <= cur_row;
      out_frame_valid <= fv_d1;
      // Rows 0 and 1 only prime the memories.
      out_valid       <= s1_valid & (s1_row >= ROW_W'(2));
      out_top         <= top_data;
      out_mid         <= mid_data;
      out_bot         <= s1_bot;
      out_col         <= s1_col;
      out_row         <= s1_row;
      out_eol         <= s1_eol;
      // The partial line is simply abandoned: coordinates hold until the next
      // rise restarts them at (0,0).
      err_short_line  <= fall & (col_reg != '0);
    end
  end

endmodule

// File: tb/tb_bayer_row_buf.sv
// -----------------------------------------------------------------------------
// tb_bayer_row_buf
//   Directed bench for bayer_row_buf. Frames are driven with pixel value
//   row*16+col; every valid output column is logged by (row,col) together with
//   the cycle it appeared in, and then compared against hand-derived values.
// -----------------------------------------------------------------------------
module tb_bayer_row_buf;

  localparam int DATA_W = 10;
  localparam int ADDR_W = 11;
  localparam int ROW_W  = 12;

  logic              sclk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W:0]   line_width = '0;
  logic              in_frame_valid = 1'b0;
  logic              in_pixel_valid = 1'b0;
  logic [DATA_W-1:0] in_pixel_data = '0;
`ifdef BAYER_PHASE_EN
  logic [1:0]        bayer_start = 2'b00;
  logic [1:0]        out_phase;
`endif
  logic              out_frame_valid;
  logic              out_valid;
  logic [DATA_W-1:0] out_top, out_mid, out_bot;
  logic [ADDR_W-1:0] out_col;
  logic [ROW_W-1:0]  out_row;
  logic              out_eol;
  logic              err_short_line;

  bayer_row_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROW_W(ROW_W)) dut (
    .sclk           (sclk),
    .rst_n          (rst_n),
    .line_width     (line_width),
    .in_frame_valid (in_frame_valid),
    .in_pixel_valid (in_pixel_valid),
    .in_pixel_data  (in_pixel_data),
`ifdef BAYER_PHASE_EN
    .bayer_start    (bayer_start),
    .out_phase      (out_phase),
`endif
    .out_frame_valid(out_frame_valid),
    .out_valid      (out_valid),
    .out_top        (out_top),
    .out_mid        (out_mid),
    .out_bot        (out_bot),
    .out_col        (out_col),
    .out_row        (out_row),
    .out_eol        (out_eol),
    .err_short_line (err_short_line)
  );

  always #5 sclk = ~sclk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int n_valid, n_eol, n_err, last_eol_col, err_cyc, ofv_cyc;
  int first_row, first_col, fall_cyc;
  int               pix_cyc   [8][16];
  int               obs_cyc   [8][16];
  logic [DATA_W-1:0] obs_top  [8][16];
  logic [DATA_W-1:0] obs_mid  [8][16];
  logic [DATA_W-1:0] obs_bot  [8][16];
  logic [1:0]        obs_phase[8][16];

  function automatic logic [DATA_W-1:0] pix(input int r, input int c);
    return DATA_W'((r * 16 + c) % 1024);
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic clear_log();
    n_valid = 0; n_eol = 0; n_err = 0; last_eol_col = -1; err_cyc = -1;
    ofv_cyc = -1; first_row = -1; first_col = -1; fall_cyc = -1;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 16; c++) begin
        pix_cyc[r][c] = -100;
        obs_cyc[r][c] = -1;
        obs_top[r][c] = '0;
        obs_mid[r][c] = '0;
        obs_bot[r][c] = '0;
        obs_phase[r][c] = 2'b00;
      end
    end
  endtask

  // Drive one cycle of inputs, then log what the outputs show just after the edge.
  task automatic cycle(input logic fv, input logic pv, input logic [DATA_W-1:0] d);
    in_frame_valid = fv;
    in_pixel_valid = pv;
    in_pixel_data  = d;
    @(posedge sclk);
    #1;
    cyc++;
    if (out_frame_valid && ofv_cyc < 0) ofv_cyc = cyc;
    if (err_short_line) begin
      n_err++;
      err_cyc = cyc;
    end
    if (out_valid) begin
      n_valid++;
      if (first_row < 0) begin
        first_row = int'(out_row);
        first_col = int'(out_col);
      end
      if (out_eol) begin
        n_eol++;
        last_eol_col = int'(out_col);
      end
      if (out_row < 8 && out_col < 16) begin
        obs_cyc[out_row[2:0]][out_col[3:0]] = cyc;
        obs_top[out_row[2:0]][out_col[3:0]] = out_top;
        obs_mid[out_row[2:0]][out_col[3:0]] = out_mid;
        obs_bot[out_row[2:0]][out_col[3:0]] = out_bot;
`ifdef BAYER_PHASE_EN
        obs_phase[out_row[2:0]][out_col[3:0]] = out_phase;
`endif
      end
    end
  endtask

  // One frame; the first pixel arrives in the rise cycle. line_width is
  // changed to lw_mid right after the first pixel. The last row carries
  // last_len pixels, then the frame ends and the pipeline drains.
  task automatic send_frame(input int lw_set, input int lw_mid, input int width,
                            input int lines, input int last_len, input int gap);
    int len;
    line_width = (ADDR_W + 1)'(lw_set);
    for (int r = 0; r < lines; r++) begin
      len = (r == lines - 1) ? last_len : width;
      for (int c = 0; c < len; c++) begin
        if (r < 8 && c < 16) pix_cyc[r][c] = cyc;
        cycle(1'b1, 1'b1, pix(r, c));
        if (r == 0 && c == 0) line_width = (ADDR_W + 1)'(lw_mid);
        for (int g = 0; g < gap; g++) cycle(1'b1, 1'b0, '0);
      end
    end
    fall_cyc = cyc;
    repeat (4) cycle(1'b0, 1'b0, '0);
  endtask

  initial begin
    // ---------------- reset state ----------------
    clear_log();
    repeat (3) @(posedge sclk);
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_fv", 32'(out_frame_valid), 0);
    check("rst_err", 32'(err_short_line), 0);
    check("rst_eol", 32'(out_eol), 0);
    check("rst_top", 32'(out_top), 0);
    check("rst_col", 32'(out_col), 0);
    check("rst_row", 32'(out_row), 0);
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, 1'b0, '0);

    // ---------------- width 4, 4 lines ----------------
    clear_log();
    send_frame(4, 4, 4, 4, 4, 0);
    check("t1_nvalid", 32'(n_valid), 8);
    check("t1_first_row", 32'(first_row), 2);
    check("t1_first_col", 32'(first_col), 0);
    check("t1_latency", 32'(obs_cyc[2][0] - pix_cyc[2][0]), 2);
    check("t1_top_2_0", 32'(obs_top[2][0]), 32'h00);
    check("t1_mid_2_0", 32'(obs_mid[2][0]), 32'h10);
    check("t1_bot_2_0", 32'(obs_bot[2][0]), 32'h20);
    check("t1_top_3_3", 32'(obs_top[3][3]), 32'h13);
    check("t1_mid_3_3", 32'(obs_mid[3][3]), 32'h23);
    check("t1_bot_3_3", 32'(obs_bot[3][3]), 32'h33);
    check("t1_neol", 32'(n_eol), 2);
    check("t1_eol_col", 32'(last_eol_col), 3);
    check("t1_fv_delay", 32'(ofv_cyc - pix_cyc[0][0]), 2);
    check("t1_no_err", 32'(n_err), 0);

    // ---------------- gapped, width 8 ----------------
    clear_log();
    send_frame(8, 8, 8, 4, 8, 2);
    check("t2_nvalid", 32'(n_valid), 16);
    for (int r = 2; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        check($sformatf("t2_top_r%0d_c%0d", r, c), 32'(obs_top[r][c]), 32'(pix(r - 2, c)));
        check($sformatf("t2_mid_r%0d_c%0d", r, c), 32'(obs_mid[r][c]), 32'(pix(r - 1, c)));
        check($sformatf("t2_bot_r%0d_c%0d", r, c), 32'(obs_bot[r][c]), 32'(pix(r, c)));
        check($sformatf("t2_lat_r%0d_c%0d", r, c), 32'(obs_cyc[r][c] - pix_cyc[r][c]), 2);
      end
    end
    check("t2_neol", 32'(n_eol), 2);
    check("t2_eol_col", 32'(last_eol_col), 7);

    // ---------------- clamping: line_width 0 ----------------
    clear_log();
    send_frame(0, 0, 2048, 3, 2048, 0);
    check("t3a_neol", 32'(n_eol), 1);
    check("t3a_eol_col", 32'(last_eol_col), 2047);
    check("t3a_nvalid", 32'(n_valid), 2048);

    // ---------------- clamping: 3000, changed to 5 mid-frame ----------------
    clear_log();
    send_frame(3000, 5, 2048, 3, 2048, 0);
    check("t3b_neol", 32'(n_eol), 1);
    check("t3b_eol_col", 32'(last_eol_col), 2047);
    check("t3b_nvalid", 32'(n_valid), 2048);
    check("t3b_top_2_5", 32'(obs_top[2][5]), 32'(pix(0, 5)));
    check("t3b_bot_2_5", 32'(obs_bot[2][5]), 32'(pix(2, 5)));

    // ---------------- short line: frame ends at col 5 of row 3 ----------------
    clear_log();
    send_frame(8, 8, 8, 4, 5, 0);
    check("t4_nerr", 32'(n_err), 1);
    check("t4_err_time", 32'(err_cyc - fall_cyc), 1);
    clear_log();
    send_frame(4, 4, 4, 3, 4, 0);
    check("t4_restart_nvalid", 32'(n_valid), 4);
    check("t4_restart_row", 32'(first_row), 2);
    check("t4_restart_col", 32'(first_col), 0);
    check("t4_restart_top", 32'(obs_top[2][0]), 32'h00);
    check("t4_restart_mid", 32'(obs_mid[2][0]), 32'h10);
    check("t4_restart_bot", 32'(obs_bot[2][0]), 32'h20);
    check("t4_restart_err", 32'(n_err), 0);

    // ---------------- reset in the middle of a line ----------------
    clear_log();
    line_width = (ADDR_W + 1)'(8);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, pix(i / 8, i % 8));
    check("t5_pre_valid", 32'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", 32'(out_valid), 0);
    check("t5_async_fv", 32'(out_frame_valid), 0);
    check("t5_async_bot", 32'(out_bot), 0);
    check("t5_async_row", 32'(out_row), 0);
    check("t5_async_col", 32'(out_col), 0);
    @(posedge sclk);
    #1;
    rst_n = 1'b1;
    clear_log();
    // Frame envelope still high after reset: these pixels must be dropped,
    // otherwise the column would advance and the following fall would flag
    // a short line.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, pix(0, i));
    repeat (4) cycle(1'b0, 1'b0, '0);
    check("t5_dropped_valid", 32'(n_valid), 0);
    check("t5_dropped_err", 32'(n_err), 0);
    clear_log();
    send_frame(4, 4, 4, 3, 4, 0);
    check("t5_nvalid", 32'(n_valid), 4);
    check("t5_top_2_1", 32'(obs_top[2][1]), 32'h01);
    check("t5_mid_2_1", 32'(obs_mid[2][1]), 32'h11);
    check("t5_bot_2_1", 32'(obs_bot[2][1]), 32'h21);

`ifdef BAYER_PHASE_EN
    // ---------------- CFA phase ----------------
    clear_log();
    bayer_start = 2'b01;
    send_frame(4, 4, 4, 4, 4, 0);
    bayer_start = 2'b10;
    check("t6_phase_2_0", 32'(obs_phase[2][0]), 32'b01);
    check("t6_phase_2_1", 32'(obs_phase[2][1]), 32'b00);
    check("t6_phase_3_0", 32'(obs_phase[3][0]), 32'b11);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
